// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the ID/EX/WB pipeline.
// It handles operand forwarding, load-use stalls, branch flush, the mul/div handshake and the halt drain.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int MD_TIMEOUT   = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             id_is_halt_i,
    input  logic             id_is_muldiv_i,
    input  logic             ex_valid_i,
    input  logic             ex_reg_wr_i,
    input  logic             ex_is_load_i,
    input  logic             ex_r0_en_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_branch_taken_i,
    input  logic             wb_valid_i,
    input  logic             wb_reg_wr_i,
    input  logic             wb_r0_en_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             md_done_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_id_o,
    output logic             bubble_ex_o,
    output logic             hold_ex_o,
    output logic             bubble_wb_o,
    output logic             flush_id_o,
    output logic             md_start_o,
    output logic             md_err_o,
    output logic             halt_sys_o
);

    localparam int CNT_W = $clog2((MD_TIMEOUT > DRAIN_CYCLES) ? MD_TIMEOUT : DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_LD_STALL = 3'd1;
    localparam logic [2:0] ST_MD_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_HALTED   = 3'd4;

    // A stage that also writes R0 (mul/div high half) matches any read of R0.
    function automatic logic src_match(
        input logic             used,
        input logic             valid,
        input logic             reg_wr,
        input logic             r0_en,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return used & valid & ((reg_wr & (rd == src)) | (r0_en & (src == {REG_W{1'b0}})));
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_start_q, md_start_d;
    logic             md_err_q, md_err_d;
    logic             halt_q, halt_d;

    logic ex_a_s, ex_b_s, wb_a_s, wb_b_s, load_use_s;

    // Source matches against EX and WB, and the forwarding selects (EX wins over WB).
    always_comb begin
        ex_a_s = src_match(id_rs1_used_i, ex_valid_i, ex_reg_wr_i, ex_r0_en_i, ex_rd_i, id_rs1_i);
        ex_b_s = src_match(id_rs2_used_i, ex_valid_i, ex_reg_wr_i, ex_r0_en_i, ex_rd_i, id_rs2_i);
        wb_a_s = src_match(id_rs1_used_i, wb_valid_i, wb_reg_wr_i, wb_r0_en_i, wb_rd_i, id_rs1_i);
        wb_b_s = src_match(id_rs2_used_i, wb_valid_i, wb_reg_wr_i, wb_r0_en_i, wb_rd_i, id_rs2_i);
        load_use_s = id_valid_i & ex_is_load_i & (ex_a_s | ex_b_s);

        if (ex_a_s && !ex_is_load_i) begin
            fwd_a_o = 2'd1;
        end else if (wb_a_s) begin
            fwd_a_o = 2'd2;
        end else begin
            fwd_a_o = 2'd0;
        end

        if (ex_b_s && !ex_is_load_i) begin
            fwd_b_o = 2'd1;
        end else if (wb_b_s) begin
            fwd_b_o = 2'd2;
        end else begin
            fwd_b_o = 2'd0;
        end
    end

    // Sequencing FSM: next state, counter and pipeline control strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_start_d  = 1'b0;
        md_err_d    = md_err_q;
        halt_d      = 1'b0;
        stall_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        hold_ex_o   = 1'b0;
        bubble_wb_o = 1'b0;
        flush_id_o  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken_i) begin
                    flush_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end else if (load_use_s) begin
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                    state_d     = ST_LD_STALL;
                end else if (id_valid_i && id_is_halt_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_ZERO;
                end else if (id_valid_i && id_is_muldiv_i) begin
                    state_d    = ST_MD_WAIT;
                    cnt_d      = CNT_ZERO;
                    md_start_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // The stalled instruction advances this cycle, so it may dispatch HALT or mul/div here.
            ST_LD_STALL: begin
                if (id_valid_i && id_is_halt_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_ZERO;
                end else if (id_valid_i && id_is_muldiv_i) begin
                    state_d    = ST_MD_WAIT;
                    cnt_d      = CNT_ZERO;
                    md_start_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MD_WAIT: begin
                if (md_done_i) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == MD_LAST) begin
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                    bubble_wb_o = 1'b1;
                    md_err_d    = 1'b1;
                    state_d     = ST_RUN;
                    cnt_d       = CNT_ZERO;
                end else begin
                    stall_id_o  = 1'b1;
                    hold_ex_o   = 1'b1;
                    bubble_wb_o = 1'b1;
                    cnt_d       = cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
                if (cnt_q == DR_LAST) begin
                    state_d = ST_HALTED;
                    cnt_d   = CNT_ZERO;
                    halt_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HALTED: begin
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
                halt_d      = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            cnt_q      <= CNT_ZERO;
            md_start_q <= 1'b0;
            md_err_q   <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
            md_err_q   <= md_err_d;
            halt_q     <= halt_d;
        end
    end

    assign md_start_o = md_start_q;
    assign md_err_o   = md_err_q;
    assign halt_sys_o = halt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_is_halt, id_is_muldiv;
    logic [3:0] id_rs1, id_rs2, ex_rd, wb_rd;
    logic       ex_valid, ex_reg_wr, ex_is_load, ex_r0_en, ex_branch_taken;
    logic       wb_valid, wb_reg_wr, wb_r0_en, md_done;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_id, bubble_ex, hold_ex, bubble_wb, flush_id;
    logic       md_start, md_err, halt_sys;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(2), .MD_TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_is_halt_i(id_is_halt), .id_is_muldiv_i(id_is_muldiv),
        .ex_valid_i(ex_valid), .ex_reg_wr_i(ex_reg_wr), .ex_is_load_i(ex_is_load),
        .ex_r0_en_i(ex_r0_en), .ex_rd_i(ex_rd), .ex_branch_taken_i(ex_branch_taken),
        .wb_valid_i(wb_valid), .wb_reg_wr_i(wb_reg_wr), .wb_r0_en_i(wb_r0_en), .wb_rd_i(wb_rd),
        .md_done_i(md_done),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_id_o(stall_id), .bubble_ex_o(bubble_ex),
        .hold_ex_o(hold_ex), .bubble_wb_o(bubble_wb), .flush_id_o(flush_id),
        .md_start_o(md_start), .md_err_o(md_err), .halt_sys_o(halt_sys)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_is_halt = 1'b0; id_is_muldiv = 1'b0;
        ex_valid = 1'b0; ex_reg_wr = 1'b0; ex_is_load = 1'b0; ex_r0_en = 1'b0; ex_rd = 4'd0;
        ex_branch_taken = 1'b0;
        wb_valid = 1'b0; wb_reg_wr = 1'b0; wb_r0_en = 1'b0; wb_rd = 4'd0;
        md_done = 1'b0;
    endtask

    task automatic set_id(input logic [3:0] a, input logic [3:0] b, input logic ua, input logic ub);
        id_valid = 1'b1; id_rs1 = a; id_rs2 = b; id_rs1_used = ua; id_rs2_used = ub;
    endtask

    task automatic set_ex(input logic [3:0] rd, input logic ld, input logic r0);
        ex_valid = 1'b1; ex_reg_wr = 1'b1; ex_rd = rd; ex_is_load = ld; ex_r0_en = r0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    int k;
    int stall_cnt;
    int start_cnt;

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk("rst_md_start", md_start, 8'd0);
        chk("rst_md_err", md_err, 8'd0);
        chk("rst_halt", halt_sys, 8'd0);
        chk("rst_stall", {stall_id, bubble_ex, hold_ex, bubble_wb, flush_id}, 8'd0);
        chk("rst_fwd", {fwd_a, fwd_b}, 8'd0);

        // ALU result in EX forwarded to both operands
        set_id(4'd3, 4'd3, 1'b1, 1'b1); set_ex(4'd3, 1'b0, 1'b0); #1;
        chk("ex_fwd_ab", {fwd_a, fwd_b}, {2'd1, 2'd1});
        chk("ex_fwd_nostall", {stall_id, bubble_ex}, 8'd0);
        wb_valid = 1'b1; wb_reg_wr = 1'b1; wb_rd = 4'd3; #1;
        chk("ex_over_wb", {fwd_a, fwd_b}, {2'd1, 2'd1});
        ex_rd = 4'd7; id_rs2 = 4'd7; #1;
        chk("mix_fwd", {fwd_a, fwd_b}, {2'd2, 2'd1});
        id_rs1_used = 1'b0; #1;
        chk("unused_src", fwd_a, 8'd0);
        idle_inputs();
        set_id(4'd0, 4'd9, 1'b1, 1'b1); set_ex(4'd9, 1'b0, 1'b1); #1;
        chk("ex_r0_fwd", {fwd_a, fwd_b}, {2'd1, 2'd1});
        ex_r0_en = 1'b0; #1;
        chk("ex_no_r0", {fwd_a, fwd_b}, {2'd0, 2'd1});

        // load-use on rs2
        idle_inputs(); tick();
        set_id(4'd1, 4'd5, 1'b1, 1'b1); set_ex(4'd5, 1'b1, 1'b0); #1;
        chk("lu_c0_stall", {stall_id, bubble_ex}, 8'b11);
        chk("lu_c0_fwd_b", fwd_b, 8'd0);
        tick();
        ex_valid = 1'b0; ex_reg_wr = 1'b0; ex_is_load = 1'b0;
        wb_valid = 1'b1; wb_reg_wr = 1'b1; wb_rd = 4'd5; #1;
        chk("lu_c1_fwd_b", fwd_b, 8'd2);
        chk("lu_c1_stall", {stall_id, bubble_ex, hold_ex}, 8'd0);
        tick(); #1;
        chk("lu_c2_run", {stall_id, bubble_ex}, 8'd0);

        // branch flush beats load-use and HALT in ID
        idle_inputs();
        set_id(4'd4, 4'd0, 1'b1, 1'b0); id_is_halt = 1'b1;
        set_ex(4'd4, 1'b1, 1'b0); ex_branch_taken = 1'b1; #1;
        chk("flush_out", {flush_id, bubble_ex, stall_id}, 8'b110);
        tick(); idle_inputs(); #1;
        chk("flush_no_drain", {stall_id, bubble_ex}, 8'd0);
        tick(); tick(); tick(); #1;
        chk("flush_no_halt", halt_sys, 8'd0);

        // mul/div with md_done five cycles after md_start
        set_id(4'd2, 4'd3, 1'b1, 1'b1); id_is_muldiv = 1'b1; #1;
        chk("md_issue_nostall", stall_id, 8'd0);
        tick(); idle_inputs();
        stall_cnt = 0; start_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            md_done = (c == 5) ? 1'b1 : 1'b0;
            #1;
            if (stall_id && hold_ex && bubble_wb) stall_cnt++;
            if (md_start) start_cnt++;
            tick();
        end
        md_done = 1'b0; #1;
        chk("md_stall_cycles", 8'(stall_cnt), 8'd5);
        chk("md_start_cycles", 8'(start_cnt), 8'd1);
        chk("md_back_run", {stall_id, hold_ex, md_start, md_err}, 8'd0);
        set_id(4'd0, 4'd6, 1'b1, 1'b1); wb_valid = 1'b1; wb_r0_en = 1'b1; wb_rd = 4'd8; #1;
        chk("md_r0_fwd", {fwd_a, fwd_b}, {2'd2, 2'd0});

        // load-use and mul/div together: stall first, then mul/div launches
        idle_inputs(); tick();
        set_id(4'd2, 4'd0, 1'b1, 1'b0); id_is_muldiv = 1'b1; set_ex(4'd2, 1'b1, 1'b0); #1;
        chk("lumd_stall", {stall_id, bubble_ex, md_start}, 8'b110);
        tick();
        ex_valid = 1'b0; ex_reg_wr = 1'b0; ex_is_load = 1'b0;
        wb_valid = 1'b1; wb_reg_wr = 1'b1; wb_rd = 4'd2; #1;
        chk("lumd_ldstall", {stall_id, md_start, fwd_a}, {1'b0, 1'b0, 6'd2});
        tick(); idle_inputs(); #1;
        chk("lumd_md_start", {md_start, stall_id, hold_ex}, 8'b111);
        md_done = 1'b1; #1;
        chk("lumd_done_drop", {stall_id, hold_ex, bubble_wb}, 8'd0);
        tick(); md_done = 1'b0; #1;

        // sync reset in MD_WAIT cycle 2
        set_id(4'd0, 4'd0, 1'b0, 1'b0); id_is_muldiv = 1'b1; #1;
        tick(); idle_inputs(); #1;
        chk("rmd_c0_start", md_start, 8'd1);
        tick(); tick(); rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("rmd_outs", {md_start, md_err, halt_sys, stall_id, bubble_ex, hold_ex, bubble_wb, flush_id}, 8'd0);
        tick(); #1;
        chk("rmd_run", {stall_id, hold_ex, md_start}, 8'd0);

        // mul/div timeout
        set_id(4'd0, 4'd0, 1'b0, 1'b0); id_is_muldiv = 1'b1; #1;
        tick(); idle_inputs(); #1;
        k = 0;
        while (!md_err && k < 200) begin
            tick(); k++;
        end
        chk("to_cycles", 8'(k), 8'd64);
        chk("to_run", {stall_id, hold_ex}, 8'd0);
        tick(); tick(); #1;
        chk("to_sticky", md_err, 8'd1);

        // HALT drain, branch in DRAIN ignored
        do_reset();
        set_id(4'd0, 4'd0, 1'b0, 1'b0); id_is_halt = 1'b1; #1;
        chk("halt_c0", {stall_id, halt_sys}, 8'd0);
        tick(); idle_inputs(); ex_branch_taken = 1'b1; #1;
        chk("drain_c1", {stall_id, bubble_ex, flush_id, halt_sys}, 8'b1100);
        tick(); ex_branch_taken = 1'b0; #1;
        chk("drain_c2", halt_sys, 8'd0);
        tick(); #1;
        chk("halt_c3", {halt_sys, stall_id, bubble_ex}, 8'b111);
        for (int c = 0; c < 4; c++) tick();
        set_id(4'd0, 4'd0, 1'b0, 1'b0); id_is_muldiv = 1'b1; #1;
        chk("halt_held", {halt_sys, stall_id, bubble_ex}, 8'b111);
        do_reset();
        chk("halt_cleared", {halt_sys, stall_id}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 3-stage pipeline (ID / EX / WB).
- Detects RAW hazards and drives the forwarding selects.
- Inserts load-use stalls and squashes the ID instruction on a taken branch.
- Runs the multi-cycle mul/div handshake.
- Drains the pipeline on HALT, then asserts halt_sys.
- Takes only decoded fields from the stage registers; it holds no datapath.

Parameters:
- REG_W, 4, register index width (16 GPRs; R0 is also the implicit mul/div high-half target).
- DRAIN_CYCLES, 2, cycles of bubbles after HALT leaves ID before halt_sys asserts.
- MD_TIMEOUT, 64, max cycles waiting for md_done before forced abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_W  ID source indices.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_is_halt  in  1  ID instruction is HALT.
- id_is_muldiv  in  1  ID instruction is MUL/DIV.
- ex_valid, ex_reg_wr, ex_is_load, ex_R0_en  in  1  EX-stage flags; R0_en = also writes R0.
- ex_rd  in  REG_W  EX destination.
- ex_branch_taken  in  1  branch resolved taken in EX.
- wb_valid, wb_reg_wr, wb_R0_en  in  1  WB-stage flags.
- wb_rd  in  REG_W  WB destination.
- md_done  in  1  mul/div unit result valid.
- fwd_a, fwd_b  out  2  operand select: 0 regfile, 1 EX ALU out, 2 WB data.
- stall_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- hold_ex  out  1  hold ID/EX.
- bubble_wb  out  1  load NOP into EX/WB.
- flush_id  out  1  squash IF/ID.
- md_start  out  1  registered one-cycle start pulse to the mul/div unit.
- md_err  out  1  sticky timeout flag.
- halt_sys  out  1  pipeline halted; sticky until rst.

Behaviour:
- **Timing and reset.** fwd_*, stall_id, bubble_ex, hold_ex, bubble_wb and flush_id are combinational from the inputs and state. md_start, md_err and halt_sys are registered. On rst: state=RUN, counters=0, every registered output=0. A rst asserted mid-MD_WAIT or mid-DRAIN aborts to RUN with no pulse.
- **Match rule.** A source s matches stage X when all hold:
  - s is used;
  - X_valid;
  - either (X_reg_wr and X_rd==s) or (X_R0_en and s==0).
- **Forwarding.**
  - fwd = 1 on an EX match with ex_is_load=0.
  - Else fwd = 2 on a WB match.
  - Else fwd = 0.
  - EX has priority over WB.
- **States:** RUN, LD_STALL, MD_WAIT, DRAIN, HALTED.
- **RUN.**
  - Flush: ex_branch_taken gives flush_id=1 and bubble_ex=1. The ID instruction is squashed, so its hazards, HALT and muldiv are all ignored. Flush has priority over every other RUN action.
  - Load-use: an EX match with ex_is_load=1 gives stall_id=1, bubble_ex=1 and next state LD_STALL.
  - HALT: id_valid and id_is_halt with no stall gives next state DRAIN, counter=0.
  - Mul/div: id_valid and id_is_muldiv with no stall/flush lets the instruction advance. Next cycle md_start=1 and state=MD_WAIT, counter=0.
- **LD_STALL.** Lasts one cycle with all stall outputs 0; the load is now in WB, so fwd=2. Then RUN re-evaluates the hazard check.
- **MD_WAIT.**
  - While waiting: stall_id=1, hold_ex=1, bubble_wb=1; counter increments.
  - md_done: outputs drop that cycle, the result latches to EX/WB, next state RUN.
  - Timeout: counter == MD_TIMEOUT-1 without md_done sets md_err=1 (sticky), bubble_ex=1, next state RUN.
  - md_start is high only on the first MD_WAIT cycle.
- **DRAIN.**
  - stall_id=1, bubble_ex=1; counter increments.
  - Counter == DRAIN_CYCLES-1 gives next state HALTED.
  - ex_branch_taken during DRAIN is ignored because HALT is older.
- **HALTED.** halt_sys=1, stall_id=1, bubble_ex=1 until rst.
- **Simultaneous load-use and muldiv in ID.** The load-use stall is taken first; muldiv proceeds after.

Test Plan:
- ADD r3 in EX, ID reads r3 on rs1 and rs2 -> fwd_a=1, fwd_b=1, no stall.
- LD r5 in EX, ID uses r5 as rs2 -> cycle 0: stall_id=1, bubble_ex=1; cycle 1: fwd_b=2, stalls 0.
- MUL in ID, md_done 5 cycles after md_start -> md_start high 1 cycle; stall_id/hold_ex high exactly 5 cycles; back to RUN. A later ID read of r0 with wb_R0_en -> fwd=2.
- md_done never arrives, MD_TIMEOUT=64 -> md_err=1 after 64 MD_WAIT cycles, state RUN.
- HALT in ID with ex_branch_taken=1 -> flush, no DRAIN. HALT alone -> halt_sys=1 exactly DRAIN_CYCLES+1 cycles after HALT leaves ID, then held.
- rst pulsed in MD_WAIT cycle 2 -> next cycle all outputs 0, state RUN, md_err unchanged at 0.
